// File: rtl/alu_pkg.sv
// Shared opcodes, flag indices, FSM states and decoder for alu_seq.
// MUL/MULI decode only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [7:0] OPC_AND   = 8'h01;
  localparam logic [7:0] OPC_OR    = 8'h02;
  localparam logic [7:0] OPC_XOR   = 8'h03;
  localparam logic [7:0] OPC_NOT   = 8'h04;
  localparam logic [7:0] OPC_ADD   = 8'h05;
  localparam logic [7:0] OPC_ADDU  = 8'h06;
  localparam logic [7:0] OPC_ADDC  = 8'h07;
  localparam logic [7:0] OPC_SUB   = 8'h09;
  localparam logic [7:0] OPC_CMP   = 8'h0B;
  localparam logic [7:0] OPC_MUL   = 8'h0E;
  localparam logic [7:0] OPC_LSHI0 = 8'h80;
  localparam logic [7:0] OPC_LSHI1 = 8'h81;
  localparam logic [7:0] OPC_ARSH  = 8'h83;
  localparam logic [7:0] OPC_LSH   = 8'h84;
  localparam logic [7:0] OPC_RSH   = 8'h8C;

  localparam logic [3:0] OPH_ADDI  = 4'h5;
  localparam logic [3:0] OPH_ADDUI = 4'h6;
  localparam logic [3:0] OPH_ADDCI = 4'h7;
  localparam logic [3:0] OPH_SUBI  = 4'h9;
  localparam logic [3:0] OPH_CMPI  = 4'hB;
  localparam logic [3:0] OPH_MULI  = 4'hE;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_RUN
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_NOT,
    OP_ADD,
    OP_ADDU,
    OP_ADDC,
    OP_SUB,
    OP_CMP,
    OP_MUL,
    OP_LSH,
    OP_RSH,
    OP_ARSH
  } op_e;

  function automatic op_e alu_decode(input logic [7:0] opc);
    logic [3:0] hi;
    op_e        op;
    hi = opc[7:4];
    unique case (1'b1)
      opc == OPC_AND: op = OP_AND;
      opc == OPC_OR:  op = OP_OR;
      opc == OPC_XOR: op = OP_XOR;
      opc == OPC_NOT: op = OP_NOT;
      opc == OPC_ADD,
      hi == OPH_ADDI: op = OP_ADD;
      opc == OPC_ADDU,
      hi == OPH_ADDUI: op = OP_ADDU;
      opc == OPC_ADDC,
      hi == OPH_ADDCI: op = OP_ADDC;
      opc == OPC_SUB,
      hi == OPH_SUBI: op = OP_SUB;
      opc == OPC_CMP,
      hi == OPH_CMPI: op = OP_CMP;
`ifdef ALU_MUL_EN
      opc == OPC_MUL,
      hi == OPH_MULI: op = OP_MUL;
`endif
      opc == OPC_LSH,
      opc == OPC_LSHI0,
      opc == OPC_LSHI1: op = OP_LSH;
      opc == OPC_RSH:  op = OP_RSH;
      opc == OPC_ARSH: op = OP_ARSH;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// Compiled only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_nx;

  assign w_acc_nx = r_mplier[0] ? r_acc + r_mcand : r_acc;

  // Done fires during the last step so the product lands on that edge.
  assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign o_prod = w_acc_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_acc    <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_nx;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CW'(WIDTH - 1))
        r_busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked ALU with internal PSR flags and iterative multiply.
// Define ALU_MUL_EN to build the MUL/MULI path.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [4:0]       flags
);

  localparam int M = WIDTH - 1;

  state_e           r_state;
  logic             r_valid;
  logic             r_wr_en;
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_flags;

  op_e              w_op;
  logic             w_acc;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [SHW-1:0]   w_amt;
  logic             w_big;
  logic [WIDTH-1:0] w_res;
  logic             w_wr;
  logic [4:0]       w_flg;

  assign in_ready  = (r_state == ST_IDLE) && (!r_valid || out_ready);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign wr_en     = r_wr_en;
  assign flags     = r_flags;

  always_comb begin
    w_op  = alu_decode(opcode);
    w_cin = (w_op == OP_ADDC) && r_flags[FLAG_C];
    w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
    w_dif = {1'b0, a} - {1'b0, b};
    w_amt = b[SHW-1:0];
    w_big = 32'(w_amt) >= 32'(WIDTH);
    w_res = '0;
    w_wr  = 1'b1;
    w_flg = '0;
    case (w_op)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_ADD, OP_ADDU, OP_ADDC: begin
        w_res = w_sum[M:0];
        w_flg[FLAG_C] = w_sum[WIDTH];
        w_flg[FLAG_F] = (a[M] == b[M]) && (w_res[M] != a[M]);
      end
      OP_SUB: begin
        w_res = w_dif[M:0];
        w_flg[FLAG_F] = (a[M] != b[M]) && (w_res[M] != a[M]);
        w_flg[FLAG_L] = a < b;
        w_flg[FLAG_C] = a >= b;
      end
      OP_CMP: w_wr = 1'b0;
      OP_LSH: w_res = w_big ? '0 : a << w_amt;
      OP_RSH: w_res = w_big ? '0 : a >> w_amt;
      OP_ARSH:
        w_res = w_big ? {WIDTH{a[M]}}
                      : $unsigned($signed(a) >>> w_amt);
      default: begin
        w_res = a;
        w_wr  = 1'b0;
      end
    endcase
    // N and Z are common to most groups; the odd ones override below.
    w_flg[FLAG_N] = w_res[M];
    w_flg[FLAG_Z] = ~|w_res;
    case (w_op)
      OP_ADDU: begin
        w_flg[FLAG_N] = 1'b0;
        w_flg[FLAG_F] = 1'b0;
      end
      OP_CMP: begin
        w_flg[FLAG_Z] = a == b;
        w_flg[FLAG_L] = a < b;
        w_flg[FLAG_N] = $signed(a) < $signed(b);
      end
      OP_LSH, OP_RSH: w_flg[FLAG_N] = 1'b0;
      OP_NOP, OP_MUL: w_flg = r_flags;
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic               w_mstart;
  logic               w_mdone;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_mres;
  logic [4:0]         w_mflg;

  assign w_mstart = w_acc && (w_op == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .reset_n(reset_n),
    .i_start(w_mstart),
    .i_a    (a),
    .i_b    (b),
    .o_done (w_mdone),
    .o_prod (w_prod)
  );

  always_comb begin
    w_mres = w_prod[M:0];
    w_mflg = '0;
    w_mflg[FLAG_N] = w_mres[M];
    w_mflg[FLAG_Z] = ~|w_mres;
    w_mflg[FLAG_C] = |w_prod[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
`ifdef ALU_MUL_EN
            if (w_op == OP_MUL) begin
              r_state <= ST_MUL_RUN;
              r_valid <= 1'b0;
            end else begin
`else
            begin
`endif
              r_valid  <= 1'b1;
              r_result <= w_res;
              r_wr_en  <= w_wr;
              r_flags  <= w_flg;
            end
          end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL_RUN: begin
          if (w_mdone) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b1;
            r_result <= w_mres;
            r_wr_en  <= 1'b1;
            r_flags  <= w_mflg;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq against an arithmetic model.
// Honors ALU_MUL_EN to expect either multiply or NOP for 0E/Ex.
module tb_alu_seq;

  localparam int W = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [7:0]   opcode = 8'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         wr_en;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int         ncomp = 0;
  int         nfail = 0;
  logic [4:0] m_psr = '0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .wr_en    (wr_en),
    .flags    (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {N,Z,F,L,C}; NOP-like codes return the current PSR.
  task automatic model(input logic [7:0] op, input logic [15:0] ia,
                       input logic [15:0] ib, output logic [15:0] r,
                       output logic w, output logic [4:0] f,
                       output bit is_mul);
    int ua, ub, sa, sb, s, ss, amt, rr, grp, cin;
    longint p;
    bit n, z, fv, l, c;
    ua = int'(ia);
    ub = int'(ib);
    sa = ia[15] ? ua - 65536 : ua;
    sb = ib[15] ? ub - 65536 : ub;
    amt = ub % 32;
    rr = 0; grp = 0; cin = 0; is_mul = 0;
    n = 0; z = 0; fv = 0; l = 0; c = 0;
    casez (op)
      8'h01: begin rr = ua & ub; grp = 1; end
      8'h02: begin rr = ua | ub; grp = 1; end
      8'h03: begin rr = ua ^ ub; grp = 1; end
      8'h04: begin rr = 65535 - ua; grp = 1; end
      8'h05, 8'h5?: grp = 2;
      8'h06, 8'h6?: grp = 3;
      8'h07, 8'h7?: begin grp = 2; cin = int'(m_psr[0]); end
      8'h09, 8'h9?: grp = 4;
      8'h0B, 8'hB?: grp = 5;
      8'h0E, 8'hE?: grp = MUL_EN ? 8 : 0;
      8'h80, 8'h81, 8'h84: begin
        rr = amt >= 16 ? 0 : int'((longint'(ua) * (longint'(1) << amt)) % 65536);
        grp = 6;
      end
      8'h8C: begin rr = amt >= 16 ? 0 : ua / (1 << amt); grp = 6; end
      8'h83: begin
        if (amt >= 16) rr = sa < 0 ? 65535 : 0;
        else rr = (sa >>> amt) & 65535;
        grp = 7;
      end
      default: grp = 0;
    endcase
    case (grp)
      2, 3: begin
        s = ua + ub + cin;
        ss = sa + sb + cin;
        rr = s % 65536;
        c = s >= 65536;
        fv = (ss > 32767) || (ss < -32768);
        n = rr >= 32768;
        if (grp == 3) begin n = 0; fv = 0; end
      end
      4: begin
        rr = (ua - ub + 65536) % 65536;
        ss = sa - sb;
        fv = (ss > 32767) || (ss < -32768);
        l = ua < ub;
        c = ua >= ub;
        n = rr >= 32768;
      end
      5: begin
        rr = 0;
        l = ua < ub;
        n = sa < sb;
      end
      8: begin
        p = longint'(ua) * longint'(ub);
        rr = int'(p % 65536);
        c = p >= 65536;
        n = rr >= 32768;
        is_mul = 1;
      end
      1, 7: n = rr >= 32768;
      default: ;
    endcase
    z = (grp == 5) ? (ua == ub) : (rr == 0);
    if (grp == 0) begin
      r = ia;
      w = 0;
      f = m_psr;
    end else begin
      r = rr[15:0];
      w = grp != 5;
      f = {n, z, fv, l, c};
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] ia,
                       input logic [15:0] ib, input bit keep,
                       input string tag);
    logic [15:0] er;
    logic        ew;
    logic [4:0]  ef;
    bit          em;
    bit          bad;
    int          n;
    model(op, ia, ib, er, ew, ef, em);
    opcode = op;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep || em) in_valid = 1'b0;
    if (em) begin
      n = 0;
      bad = 0;
      while (!out_valid && n < 100) begin
        if (in_ready) bad = 1;
        @(posedge clk);
        #1;
        n++;
      end
      check({tag, ".latency"}, 32'(n), 32'd16);
      check({tag, ".busy"}, 32'(bad), 32'd0);
    end
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".wr_en"}, 32'(wr_en), 32'(ew));
    check({tag, ".flags"}, 32'(flags), 32'(ef));
    m_psr = ef;
  endtask

  initial begin
    logic [15:0] hold_r;
    logic [4:0]  hold_f;
    logic [7:0]  opl [22];
    logic [7:0]  op;
    opl = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h50, 8'h06,
            8'h60, 8'h07, 8'h70, 8'h09, 8'h90, 8'h0B, 8'hB0, 8'h0E,
            8'hE0, 8'h84, 8'h80, 8'h81, 8'h8C, 8'h83};

    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst.ready", 32'(in_ready), 32'd1);

    issue(8'h05, 16'h7FFF, 16'h0001, 0, "add_ovf");
    check("add_ovf.k", {11'd0, flags, result}, {11'd0, 5'b10100, 16'h8000});

    issue(8'h05, 16'hFFFF, 16'h0001, 1, "add_c");
    check("add_c.k", {11'd0, flags, result}, {11'd0, 5'b01001, 16'h0000});
    issue(8'h07, 16'h0000, 16'h0000, 0, "addc");
    check("addc.k", {11'd0, flags, result}, {11'd0, 5'b00000, 16'h0001});
    @(posedge clk);
    #1;
    check("valid_clear", 32'(out_valid), 32'd0);

    issue(8'h0B, 16'h0001, 16'hFFFF, 0, "cmp");
    check("cmp.k", {10'd0, wr_en, flags, result},
          {10'd0, 1'b0, 5'b00010, 16'h0000});

    issue(8'h0E, 16'h0100, 16'h0100, 0, "mul");
    if (MUL_EN)
      check("mul.k", {11'd0, flags, result}, {11'd0, 5'b01001, 16'h0000});
    else
      check("mul_nop.k", {11'd0, flags, result}, {11'd0, 5'b00010, 16'h0100});

    issue(8'h03, 16'hF0F0, 16'hFF00, 0, "xor");
    out_ready = 1'b0;
    hold_r = result;
    hold_f = flags;
    opcode = 8'h01;
    a = 16'h1234;
    b = 16'h00FF;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp.hold", {10'd0, out_valid, flags, result},
            {10'd0, 1'b1, hold_f, hold_r});
      check("bp.ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release", 32'(in_ready), 32'd1);
    issue(8'h01, 16'h1234, 16'h00FF, 0, "bp.and");

    if (MUL_EN) begin
      opcode = 8'h0E;
      a = 16'h0003;
      b = 16'h0005;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
    end
    #3;
    reset_n = 1'b0;
    #1;
    check("rst2.all", {10'd0, out_valid, flags, result}, 32'd0);
    check("rst2.wr_en", 32'(wr_en), 32'd0);
    m_psr = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst2.quiet", {30'd0, out_valid, in_ready}, 32'd1);
    issue(8'h05, 16'h1234, 16'h1111, 0, "rst2.add");
    issue(8'h83, 16'h8000, 16'd20, 0, "arsh");
    check("arsh.k", {11'd0, flags, result}, {11'd0, 5'b10000, 16'hFFFF});

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0)
        op = 8'($urandom_range(0, 255));
      else begin
        op = opl[$urandom_range(0, 21)];
        if (op[7:4] != 4'h0 && op[7:4] != 4'h8)
          op[3:0] = 4'($urandom_range(0, 15));
      end
      issue(op, 16'($urandom), 16'($urandom),
            $urandom_range(0, 1) == 1, "rand");
    end
    in_valid = 1'b0;
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
